// File: rtl/alu_arbiter_pkg.sv
// Shared processor definitions: opcode map, ALU function decode and the
// response-register state type used by the arbiter.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned CNT_W  = 16;

  localparam logic [6:0] OPC_ADD    = 7'd1;
  localparam logic [6:0] OPC_SLT    = 7'd2;
  localparam logic [6:0] OPC_SLTU   = 7'd3;
  localparam logic [6:0] OPC_XOR    = 7'd4;
  localparam logic [6:0] OPC_OR     = 7'd5;
  localparam logic [6:0] OPC_AND    = 7'd6;
  localparam logic [6:0] OPC_SLL    = 7'd7;
  localparam logic [6:0] OPC_SRL    = 7'd8;
  localparam logic [6:0] OPC_SRA    = 7'd9;
  localparam logic [6:0] OPC_ADD_A  = 7'd10;
  localparam logic [6:0] OPC_SUB    = 7'd11;
  localparam logic [6:0] OPC_SLL_A  = 7'd12;
  localparam logic [6:0] OPC_SLT_A  = 7'd13;
  localparam logic [6:0] OPC_SLTU_A = 7'd14;
  localparam logic [6:0] OPC_XOR_A  = 7'd15;
  localparam logic [6:0] OPC_SRL_A  = 7'd16;
  localparam logic [6:0] OPC_SRA_A  = 7'd17;
  localparam logic [6:0] OPC_OR_A   = 7'd18;
  localparam logic [6:0] OPC_AND_A  = 7'd19;
  localparam logic [6:0] OPC_EQ     = 7'd20;
  localparam logic [6:0] OPC_NE     = 7'd21;
  localparam logic [6:0] OPC_LT     = 7'd22;
  localparam logic [6:0] OPC_GE     = 7'd23;
  localparam logic [6:0] OPC_LTU    = 7'd24;
  localparam logic [6:0] OPC_GEU    = 7'd25;
  localparam logic [6:0] OPC_ADD_B  = 7'd28;
  localparam logic [6:0] OPC_ADD_C  = 7'd33;

  typedef enum logic [3:0] {
    FN_NONE = 4'd0,
    FN_ADD  = 4'd1,
    FN_SUB  = 4'd2,
    FN_SLT  = 4'd3,
    FN_SLTU = 4'd4,
    FN_XOR  = 4'd5,
    FN_OR   = 4'd6,
    FN_AND  = 4'd7,
    FN_SLL  = 4'd8,
    FN_SRL  = 4'd9,
    FN_SRA  = 4'd10,
    FN_EQ   = 4'd11,
    FN_NE   = 4'd12,
    FN_GE   = 4'd13,
    FN_GEU  = 4'd14
  } alu_fn_e;

  typedef struct packed {
    alu_fn_e fn;
    logic    legal;
  } alu_dec_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Several opcodes alias the same function; anything unlisted is illegal.
  function automatic alu_dec_t decode_op(input logic [6:0] opcode);
    alu_dec_t d;
    d.legal = 1'b1;
    case (opcode)
      OPC_ADD, OPC_ADD_A, OPC_ADD_B, OPC_ADD_C: d.fn = FN_ADD;
      OPC_SUB:                                  d.fn = FN_SUB;
      OPC_SLT, OPC_SLT_A, OPC_LT:               d.fn = FN_SLT;
      OPC_SLTU, OPC_SLTU_A, OPC_LTU:            d.fn = FN_SLTU;
      OPC_XOR, OPC_XOR_A:                       d.fn = FN_XOR;
      OPC_OR, OPC_OR_A:                         d.fn = FN_OR;
      OPC_AND, OPC_AND_A:                       d.fn = FN_AND;
      OPC_SLL, OPC_SLL_A:                       d.fn = FN_SLL;
      OPC_SRL, OPC_SRL_A:                       d.fn = FN_SRL;
      OPC_SRA, OPC_SRA_A:                       d.fn = FN_SRA;
      OPC_EQ:                                   d.fn = FN_EQ;
      OPC_NE:                                   d.fn = FN_NE;
      OPC_GE:                                   d.fn = FN_GE;
      OPC_GEU:                                  d.fn = FN_GEU;
      default: begin
        d.fn    = FN_NONE;
        d.legal = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; illegal opcodes yield a zero result with err set.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [6:0]  opcode,
  output logic [31:0] result,
  output logic        err
);

  alu_dec_t   dec_s;
  logic [4:0] shamt_s;

  assign dec_s   = decode_op(opcode);
  assign shamt_s = op2[4:0];

  // Function select; compare results are zero-extended single bits.
  always_comb begin
    result = 32'd0;
    err    = ~dec_s.legal;
    case (dec_s.fn)
      FN_ADD:  result = op1 + op2;
      FN_SUB:  result = op1 - op2;
      FN_SLT:  result = {31'd0, ($signed(op1) < $signed(op2))};
      FN_SLTU: result = {31'd0, (op1 < op2)};
      FN_XOR:  result = op1 ^ op2;
      FN_OR:   result = op1 | op2;
      FN_AND:  result = op1 & op2;
      FN_SLL:  result = op1 << shamt_s;
      FN_SRL:  result = op1 >> shamt_s;
      FN_SRA:  result = $unsigned($signed(op1) >>> shamt_s);
      FN_EQ:   result = {31'd0, (op1 == op2)};
      FN_NE:   result = {31'd0, (op1 != op2)};
      FN_GE:   result = {31'd0, ($signed(op1) >= $signed(op2))};
      FN_GEU:  result = {31'd0, (op1 >= op2)};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to one shared ALU, with a one-entry
// registered response slot and per-requester accept counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [6:0]       req0_opcode,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [6:0]       req1_opcode,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  rsp_state_e       state_r, next_state_s;
  logic             prio_r;
  logic             grant_s;
  logic             accept_s;
  logic             xfer_s;
  logic [31:0]      alu_op1_s;
  logic [31:0]      alu_op2_s;
  logic [6:0]       alu_opcode_s;
  logic [TAG_W-1:0] win_tag_s;
  logic [31:0]      alu_result_s;
  logic             alu_err_s;
  logic [31:0]      rsp_result_r;
  logic             rsp_src_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic             rsp_err_r;
  logic [15:0]      cnt0_r;
  logic [15:0]      cnt1_r;

  // Grant selection, handshake and operand steering for the winner.
  // prio_r names the requester that wins a tie.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = prio_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    accept_s   = rst_n & ((state_r == RSP_EMPTY) | rsp_ready);
    xfer_s     = accept_s & (req0_valid | req1_valid);
    req0_ready = xfer_s & ~grant_s;
    req1_ready = xfer_s & grant_s;

    if (grant_s) begin
      alu_op1_s    = req1_op1;
      alu_op2_s    = req1_op2;
      alu_opcode_s = req1_opcode;
      win_tag_s    = req1_tag;
    end else begin
      alu_op1_s    = req0_op1;
      alu_op2_s    = req0_op2;
      alu_opcode_s = req0_opcode;
      win_tag_s    = req0_tag;
    end
  end

  alu_arbiter_alu u_alu (
    .op1    (alu_op1_s),
    .op2    (alu_op2_s),
    .opcode (alu_opcode_s),
    .result (alu_result_s),
    .err    (alu_err_s)
  );

  // Response slot next-state: a new accept always refills the slot.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RSP_EMPTY: begin
        if (xfer_s) next_state_s = RSP_FULL;
        else        next_state_s = RSP_EMPTY;
      end
      RSP_FULL: begin
        if (xfer_s)         next_state_s = RSP_FULL;
        else if (rsp_ready) next_state_s = RSP_EMPTY;
        else                next_state_s = RSP_FULL;
      end
      default: next_state_s = RSP_EMPTY;
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RSP_EMPTY;
      prio_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (xfer_s) prio_r <= ~grant_s;
    end
  end

  // Response payload, captured only on an accepted transfer so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_r <= 32'd0;
      rsp_src_r    <= 1'b0;
      rsp_tag_r    <= '0;
      rsp_err_r    <= 1'b0;
    end else if (xfer_s) begin
      rsp_result_r <= alu_result_s;
      rsp_src_r    <= grant_s;
      rsp_tag_r    <= win_tag_s;
      rsp_err_r    <= alu_err_s;
    end
  end

  // Per-requester accept counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= 16'd0;
      cnt1_r <= 16'd0;
    end else begin
      if (req0_valid && req0_ready) cnt0_r <= cnt0_r + 16'd1;
      if (req1_valid && req1_ready) cnt1_r <= cnt1_r + 16'd1;
    end
  end

  assign rsp_valid  = (state_r == RSP_FULL);
  assign rsp_result = rsp_result_r;
  assign rsp_src    = rsp_src_r;
  assign rsp_tag    = rsp_tag_r;
  assign rsp_err    = rsp_err_r;
  assign cnt0       = cnt0_r;
  assign cnt1       = cnt1_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [31:0]      req0_op1, req0_op2;
  logic [6:0]       req0_opcode;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [31:0]      req1_op1, req1_op2;
  logic [6:0]       req1_opcode;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [15:0]      cnt0, cnt1;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_opcode(req0_opcode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_opcode(req1_opcode), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_src(rsp_src), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_op1 = 32'd0; req0_op2 = 32'd0; req0_opcode = 7'd0; req0_tag = 4'd0;
    req1_valid = 1'b0; req1_op1 = 32'd0; req1_op2 = 32'd0; req1_opcode = 7'd0; req1_tag = 4'd0;
  endtask

  task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op, input logic [3:0] tag);
    req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_opcode = op; req0_tag = tag;
  endtask

  task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op, input logic [3:0] tag);
    req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_opcode = op; req1_tag = tag;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    idle_inputs();
    set_req0(32'd5, 32'd7, 7'd1, 4'd3);
    set_req1(32'd5, 32'd7, 7'd1, 4'd4);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result} !== 39'd0) begin
      n_err++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result});
    end
    n_cmp++;
    if ({cnt0, cnt1} !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt: got %h want 0", {cnt0, cnt1});
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release_valid: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_single;
    apply_reset();
    rsp_ready = 1'b1;
    set_req0(32'd5, 32'd7, 7'd1, 4'd3);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result} !== {1'b1, 1'b0, 4'd3, 1'b0, 32'd12}) begin
      n_err++; $display("FAIL single_rsp: got %h want %h", {rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result},
                        {1'b1, 1'b0, 4'd3, 1'b0, 32'd12});
    end
    n_cmp++;
    if ({cnt0, cnt1} !== {16'd1, 16'd0}) begin
      n_err++; $display("FAIL single_cnt: got %h want 00010000", {cnt0, cnt1});
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic        exp_src;
    logic [31:0] exp_res;
    logic [3:0]  exp_tag;
    logic [1:0]  exp_rdy;
    apply_reset();
    rsp_ready = 1'b1;
    set_req0(32'd10, 32'd3, 7'd11, 4'h1);
    set_req1(32'hF0F0_1234, 32'h0FF0_4321, 7'd4, 4'h2);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL rr_first_ready: got %b want 10", {req0_ready, req1_ready});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_src = i[0];
      exp_res = exp_src ? 32'hFF00_5115 : 32'd7;
      exp_tag = exp_src ? 4'h2 : 4'h1;
      exp_rdy = exp_src ? 2'b10 : 2'b01;
      n_cmp++;
      if ({rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result} !== {1'b1, exp_src, exp_tag, 1'b0, exp_res}) begin
        n_err++; $display("FAIL rr_rsp[%0d]: got %h want %h", i, {rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result},
                          {1'b1, exp_src, exp_tag, 1'b0, exp_res});
      end
      n_cmp++;
      if ({req0_ready, req1_ready} !== exp_rdy) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_rdy);
      end
    end
    idle_inputs();
    n_cmp++;
    if ({cnt0, cnt1} !== {16'd2, 16'd2}) begin
      n_err++; $display("FAIL rr_cnt: got %h want 00020002", {cnt0, cnt1});
    end
    tick();
  endtask

  task automatic test_hold;
    apply_reset();
    rsp_ready = 1'b0;
    set_req0(32'd10, 32'd3, 7'd11, 4'h1);
    set_req1(32'hF0F0_1234, 32'h0FF0_4321, 7'd4, 4'h2);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL hold_empty_ready: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_err++; $display("FAIL hold_ready[%0d]: got %b want 00", k, {req0_ready, req1_ready});
      end
      n_cmp++;
      if ({rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result} !== {1'b1, 1'b0, 4'h1, 1'b0, 32'd7}) begin
        n_err++; $display("FAIL hold_rsp[%0d]: got %h want %h", k, {rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result},
                          {1'b1, 1'b0, 4'h1, 1'b0, 32'd7});
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL hold_release_ready: got %b want 01", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result} !== {1'b1, 1'b1, 4'h2, 1'b0, 32'hFF00_5115}) begin
      n_err++; $display("FAIL hold_b2b_rsp: got %h want %h", {rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result},
                        {1'b1, 1'b1, 4'h2, 1'b0, 32'hFF00_5115});
    end
    tick();
    n_cmp++;
    if ({rsp_valid, cnt0, cnt1} !== {1'b0, 16'd1, 16'd1}) begin
      n_err++; $display("FAIL hold_drain: got %h want %h", {rsp_valid, cnt0, cnt1}, {1'b0, 16'd1, 16'd1});
    end
  endtask

  task automatic test_alu_ops;
    vec_t vecs [24];
    vecs = '{
      '{7'd1,   32'd5,          32'd7,          32'd12,         1'b0},
      '{7'd11,  32'd3,          32'd10,         32'hFFFF_FFF9,  1'b0},
      '{7'd2,   32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0},
      '{7'd3,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
      '{7'd7,   32'd1,          32'd33,         32'd2,          1'b0},
      '{7'd12,  32'd3,          32'd2,          32'd12,         1'b0},
      '{7'd8,   32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0},
      '{7'd9,   32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0},
      '{7'd17,  32'hFFFF_FF00,  32'd4,          32'hFFFF_FFF0,  1'b0},
      '{7'd6,   32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1'b0},
      '{7'd5,   32'h0000_00F0,  32'h0000_003C,  32'h0000_00FC,  1'b0},
      '{7'd20,  32'd5,          32'd5,          32'd1,          1'b0},
      '{7'd21,  32'd5,          32'd5,          32'd0,          1'b0},
      '{7'd22,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0},
      '{7'd23,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
      '{7'd24,  32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0},
      '{7'd25,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0},
      '{7'd28,  32'd1,          32'd2,          32'd3,          1'b0},
      '{7'd33,  32'd1,          32'd2,          32'd3,          1'b0},
      '{7'd26,  32'd1,          32'd1,          32'd0,          1'b1},
      '{7'd27,  32'd1,          32'd1,          32'd0,          1'b1},
      '{7'd0,   32'd1,          32'd1,          32'd0,          1'b1},
      '{7'd34,  32'd1,          32'd1,          32'd0,          1'b1},
      '{7'd127, 32'd1,          32'd1,          32'd0,          1'b1}
    };
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      set_req0(vecs[i].a, vecs[i].b, vecs[i].op, 4'(i));
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, vecs[i].err, vecs[i].res}) begin
        n_err++; $display("FAIL alu_op%0d: got v/e/r %b/%b/%h want 1/%b/%h", vecs[i].op,
                          rsp_valid, rsp_err, rsp_result, vecs[i].err, vecs[i].res);
      end
    end
    idle_inputs();
    n_cmp++;
    if (cnt0 !== 16'd24) begin
      n_err++; $display("FAIL alu_cnt0: got %0d want 24", cnt0);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold;
    apply_reset();
    rsp_ready = 1'b0;
    set_req0(32'd10, 32'd3, 7'd11, 4'h1);
    set_req1(32'd1, 32'd1, 7'd1, 4'h2);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result, cnt0, cnt1} !== 71'd0) begin
      n_err++; $display("FAIL midrst_state: got %h want 0", {rsp_valid, rsp_src, rsp_tag, rsp_err, rsp_result, cnt0, cnt1});
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_err++; $display("FAIL midrst_ready: got %b want 00", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid);
    end
    set_req0(32'd10, 32'd3, 7'd11, 4'h1);
    set_req1(32'd1, 32'd1, 7'd1, 4'h2);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL midrst_tie: got %b want 10", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_result} !== {1'b1, 1'b0, 32'd7}) begin
      n_err++; $display("FAIL midrst_first_rsp: got %h want %h", {rsp_valid, rsp_src, rsp_result}, {1'b1, 1'b0, 32'd7});
    end
    tick();
  endtask

  task automatic test_wrap;
    apply_reset();
    rsp_ready = 1'b1;
    set_req1(32'd1, 32'd1, 7'd1, 4'hA);
    repeat (65535) tick();
    n_cmp++;
    if ({cnt0, cnt1} !== {16'd0, 16'hFFFF}) begin
      n_err++; $display("FAIL wrap_preset: got %h want 0000ffff", {cnt0, cnt1});
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({cnt0, cnt1} !== 32'd0) begin
      n_err++; $display("FAIL wrap_cnt1: got %h want 00000000", {cnt0, cnt1});
    end
    n_cmp++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_result} !== {1'b1, 1'b1, 4'hA, 32'd2}) begin
      n_err++; $display("FAIL wrap_rsp: got %h want %h", {rsp_valid, rsp_src, rsp_tag, rsp_result}, {1'b1, 1'b1, 4'hA, 32'd2});
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_alu_ops();
    test_reset_mid_hold();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of requester transaction tag.
REQ-002 SHALL have ports: clk  in  1  single clock, all state rising-edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have, for i in {0,1}: reqi_valid  in  1  requester i offers an operation.
REQ-005 SHALL have reqi_ready  out  1  requester i operation accepted this cycle.
REQ-006 SHALL have reqi_op1, reqi_op2  in  32 each  operands; reqi_opcode  in  7  ALU operation code; reqi_tag  in  TAG_W  opaque tag.
REQ-007 SHALL have rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  32; rsp_src  out  1 (winning requester); rsp_tag  out  TAG_W; rsp_err  out  1 (illegal opcode).
REQ-008 SHALL have cnt0, cnt1  out  16 each  operations accepted per requester.

Function
REQ-009 SHALL share one combinational ALU between both requesters, one operation issued per cycle maximum.
REQ-010 SHALL hold a one-entry response register with two states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-011 SHALL accept an operation when the response register is EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-012 SHALL assert reqi_ready combinationally only for the granted requester and only when REQ-011 holds; a transfer is reqi_valid & reqi_ready.
REQ-013 SHALL grant the sole valid requester; when both are valid, SHALL grant the requester not granted last (round-robin pointer updated only on an accepted transfer).
REQ-014 SHALL capture ALU result, winner index, tag and error flag at the accepting edge; rsp_valid rises the following cycle (latency 1, throughput 1/cycle with rsp_ready=1).
REQ-015 Transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept (back-to-back) or on !rsp_ready (hold).
REQ-016 SHALL keep rsp_result, rsp_src, rsp_tag, rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-017 Legal opcodes SHALL be 1..25, 28, 33; any other opcode SHALL still be accepted, produce rsp_result=0 and rsp_err=1.
REQ-018 Opcode semantics: 1/10/28/33 add; 11 sub; 2/13 signed less-than; 3/14 unsigned less-than; 4/15 xor; 5/18 or; 6/19 and; 7/12 shift-left by op2[4:0]; 8/16 logical right; 9/17 arithmetic right; 20 eq; 21 ne; 22 signed lt; 23 signed ge; 24 unsigned lt; 25 unsigned ge; compare results 32'd1/32'd0.
REQ-019 SHALL increment cnti by 1 per accepted transfer from requester i, wrapping 16'hFFFF->0.
REQ-020 Request inputs SHALL be ignored when reqi_valid=0; a valid request not granted SHALL not be consumed.

Reset
REQ-021 rst_n low SHALL immediately force rsp_valid=0 (EMPTY), rsp_result=0, rsp_src=0, rsp_tag=0, rsp_err=0, cnt0=cnt1=0, round-robin pointer so requester 0 wins the first tie.
REQ-022 Reset asserted with FULL response SHALL discard that response; no response SHALL appear after release until a new accept.
REQ-023 reqi_ready SHALL be 0 while rst_n is low.

Structure
REQ-024 Opcode constants and legal-opcode list SHALL live in the shared processor package, reused by the decoder.
REQ-025 SHALL instantiate the existing ALU module as its single sub-module; arbitration, response register and counters stay in alu_arbiter.

Verification
REQ-026 req0 only: op1=5, op2=7, opcode=1, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, result=12, src=0, tag=3, err=0, cnt0=1.
REQ-027 Both valid continuously after reset, rsp_ready=1, opcodes 11 (10-3) and 4 -> grants alternate 0,1,0,1; results 7 and op1^op2; one response per cycle.
REQ-028 rsp_ready=0 for 3 cycles with FULL -> response held unchanged, both reqi_ready=0; rsp_ready=1 -> drain and new accept same edge.
REQ-029 opcode=7'd26, op1=op2=1 -> result=0, err=1, counter still increments.
REQ-030 Assert rst_n low mid-hold with FULL, release -> rsp_valid=0, counters 0, first tie granted to requester 0.
REQ-031 cnt1 preset via 65535 accepts -> next accept wraps cnt1 to 0.
